// File: rtl/cpu_sequencer.sv
// Multi-cycle sequencer for the 10-bit core: wraps the combinational Control decoder.
// Optional retired-instruction counter is built only when SEQ_PERF_CNT_EN is defined.
module cpu_sequencer #(
  parameter int unsigned IMEM_WAIT   = 1,
  parameter int unsigned MUL_TIMEOUT = 15
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        reg_write_i,
  input  logic        mem_write_i,
  input  logic        mem_or_alu_i,
  input  logic        mul_op_i,
  input  logic        beq_i,
  input  logic        bne_i,
  input  logic        jump_i,
  input  logic        halt_i,
  input  logic        zero_i,
  input  logic        mul_done_i,
  output logic        ir_we_o,
  output logic        pc_we_o,
  output logic [1:0]  pc_sel_o,
  output logic        rf_we_o,
  output logic        dmem_we_o,
  output logic        mul_start_o,
  output logic        halted_o,
  output logic        error_o,
  output logic [3:0]  state_o,
  output logic [15:0] instr_cnt_o
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_MULW   = 4'd4,
    S_MEM    = 4'd5,
    S_WB     = 4'd6,
    S_HALT   = 4'd7,
    S_ERR    = 4'd8
  } state_e;

  localparam logic [1:0] SEL_INC    = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JUMP   = 2'b10;
  localparam logic [2:0] WAIT_LAST  = 3'(IMEM_WAIT);
  localparam logic [7:0] TMO_LAST   = 8'(MUL_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [2:0] wait_q, wait_d;
  logic [7:0] tmo_q, tmo_d;
  logic [1:0] pc_sel_q, pc_sel_d;
  logic       rw_q, rw_d;
  logic       mw_q, mw_d;
  logic       moa_q, moa_d;
  logic       beq_q, beq_d;
  logic       bne_q, bne_d;
  logic       jmp_q, jmp_d;

  logic       ir_we, pc_we, rf_we, dmem_we, mul_start;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      tmo_q    <= '0;
      pc_sel_q <= SEL_INC;
      rw_q     <= 1'b0;
      mw_q     <= 1'b0;
      moa_q    <= 1'b0;
      beq_q    <= 1'b0;
      bne_q    <= 1'b0;
      jmp_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      tmo_q    <= tmo_d;
      pc_sel_q <= pc_sel_d;
      rw_q     <= rw_d;
      mw_q     <= mw_d;
      moa_q    <= moa_d;
      beq_q    <= beq_d;
      bne_q    <= bne_d;
      jmp_q    <= jmp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    tmo_d     = tmo_q;
    pc_sel_d  = pc_sel_q;
    rw_d      = rw_q;
    mw_d      = mw_q;
    moa_d     = moa_q;
    beq_d     = beq_q;
    bne_d     = bne_q;
    jmp_d     = jmp_q;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    rf_we     = 1'b0;
    dmem_we   = 1'b0;
    mul_start = 1'b0;

    case (state_q)
      S_IDLE: begin
        wait_d = '0;
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (wait_q == WAIT_LAST) begin
          ir_we   = 1'b1;
          wait_d  = '0;
          state_d = S_DECODE;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      S_DECODE: begin
        // Control decodes the freshly loaded IR this cycle; freeze its view here.
        rw_d     = reg_write_i;
        mw_d     = mem_write_i;
        moa_d    = mem_or_alu_i;
        beq_d    = beq_i;
        bne_d    = bne_i;
        jmp_d    = jump_i;
        tmo_d    = '0;
        pc_sel_d = SEL_INC;
        if (halt_i) begin
          state_d = S_HALT;
        end else if (mul_op_i) begin
          mul_start = 1'b1;
          state_d   = S_MULW;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (jmp_q)
          pc_sel_d = SEL_JUMP;
        else if ((beq_q && zero_i) || (bne_q && !zero_i))
          pc_sel_d = SEL_BRANCH;
        else
          pc_sel_d = SEL_INC;
        state_d = (mw_q || moa_q) ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_we = mw_q;
        state_d = S_WB;
      end
      S_MULW: begin
        // A late MUL_DONE still beats the timeout in the same cycle.
        if (mul_done_i) begin
          pc_sel_d = SEL_INC;
          state_d  = S_WB;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_WB: begin
        rf_we   = rw_q;
        pc_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  assign ir_we_o     = ir_we;
  assign pc_we_o     = pc_we;
  assign pc_sel_o    = (state_q == S_WB) ? pc_sel_q : SEL_INC;
  assign rf_we_o     = rf_we;
  assign dmem_we_o   = dmem_we;
  assign mul_start_o = mul_start;
  assign halted_o    = (state_q == S_HALT);
  assign error_o     = (state_q == S_ERR);
  assign state_o     = state_q;

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] instr_cnt_q, instr_cnt_d;

  always_comb begin
    instr_cnt_d = instr_cnt_q;
    if (state_q == S_WB && instr_cnt_q != 16'hFFFF)
      instr_cnt_d = instr_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) instr_cnt_q <= '0;
    else         instr_cnt_q <= instr_cnt_d;
  end

  assign instr_cnt_o = instr_cnt_q;
`else
  assign instr_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer (IMEM_WAIT=1, MUL_TIMEOUT=15).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        reg_write = 1'b0, mem_write = 1'b0, mem_or_alu = 1'b0, mul_op = 1'b0;
  logic        beq = 1'b0, bne = 1'b0, jump = 1'b0, halt = 1'b0;
  logic        zero = 1'b0, mul_done = 1'b0;
  logic        ir_we_o, pc_we_o, rf_we_o, dmem_we_o, mul_start_o, halted_o, error_o;
  logic [1:0]  pc_sel_o;
  logic [3:0]  state_o;
  logic [15:0] instr_cnt_o;

  int checks = 0;
  int errors = 0;

  // {state[3:0], ir_we, pc_we, pc_sel[1:0], rf_we, dmem_we, mul_start}
  logic [10:0] obs;
  assign obs = {state_o, ir_we_o, pc_we_o, pc_sel_o, rf_we_o, dmem_we_o, mul_start_o};

  always #5 clk = ~clk;

  cpu_sequencer #(.IMEM_WAIT(1), .MUL_TIMEOUT(15)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .reg_write_i(reg_write), .mem_write_i(mem_write), .mem_or_alu_i(mem_or_alu),
    .mul_op_i(mul_op), .beq_i(beq), .bne_i(bne), .jump_i(jump), .halt_i(halt),
    .zero_i(zero), .mul_done_i(mul_done),
    .ir_we_o(ir_we_o), .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o), .rf_we_o(rf_we_o),
    .dmem_we_o(dmem_we_o), .mul_start_o(mul_start_o), .halted_o(halted_o),
    .error_o(error_o), .state_o(state_o), .instr_cnt_o(instr_cnt_o)
  );

  // {reg_write, mem_write, mem_or_alu, mul_op, beq, bne, jump, halt}
  task automatic set_ctl(input logic [7:0] v);
    {reg_write, mem_write, mem_or_alu, mul_op, beq, bne, jump, halt} = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0; mul_done = 1'b0; zero = 1'b0;
    set_ctl(8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called on a falling edge in IDLE; returns on the falling edge of FETCH cycle 0.
  task automatic launch();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== 11'b0000_0_0_00_0_0_0) begin
      errors++; $display("FAIL reset_outputs got %h want %h", obs, 11'h000);
    end
    checks++;
    if ({halted_o, error_o, instr_cnt_o} !== 18'd0) begin
      errors++; $display("FAIL reset_flags got %h want 0", {halted_o, error_o, instr_cnt_o});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (state_o !== 4'd0) begin
      errors++; $display("FAIL reset_idle_no_start got %0d want 0", state_o);
    end
  endtask

  task automatic test_add();
    logic [10:0] exp_v [6];
    exp_v[0] = 11'b0001_0_0_00_0_0_0;
    exp_v[1] = 11'b0001_1_0_00_0_0_0;
    exp_v[2] = 11'b0010_0_0_00_0_0_0;
    exp_v[3] = 11'b0011_0_0_00_0_0_0;
    exp_v[4] = 11'b0110_0_1_00_1_0_0;
    exp_v[5] = 11'b0001_0_0_00_0_0_0;
    do_reset();
    set_ctl(8'b1000_0000);
    launch();
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (obs !== exp_v[c]) begin
        errors++; $display("FAIL add cyc%0d got %h want %h", c, obs, exp_v[c]);
      end
      if (c == 3) reg_write = 1'b0;  // must be ignored after DECODE
    end
  endtask

  task automatic test_branch();
    logic [7:0]  ctl_t  [6];
    logic        zero_t [6];
    logic [1:0]  sel_t  [6];
    ctl_t[0] = 8'b0000_1000; zero_t[0] = 1'b1; sel_t[0] = 2'b01;  // BEQ taken
    ctl_t[1] = 8'b0000_1000; zero_t[1] = 1'b0; sel_t[1] = 2'b00;  // BEQ not taken
    ctl_t[2] = 8'b0000_0100; zero_t[2] = 1'b1; sel_t[2] = 2'b00;  // BNE not taken
    ctl_t[3] = 8'b0000_0100; zero_t[3] = 1'b0; sel_t[3] = 2'b01;  // BNE taken
    ctl_t[4] = 8'b0000_1010; zero_t[4] = 1'b1; sel_t[4] = 2'b10;  // JUMP beats BEQ
    ctl_t[5] = 8'b0000_0000; zero_t[5] = 1'b1; sel_t[5] = 2'b00;  // unknown -> NOP
    for (int k = 0; k < 6; k++) begin
      do_reset();
      set_ctl(ctl_t[k]);
      zero = zero_t[k];
      launch();
      repeat (4) @(negedge clk);
      checks++;
      if (obs !== {4'd6, 1'b0, 1'b1, sel_t[k], 3'b000}) begin
        errors++; $display("FAIL branch case%0d wb got %h want %h", k, obs, {4'd6, 1'b0, 1'b1, sel_t[k], 3'b000});
      end
      @(negedge clk);
      checks++;
      if (state_o !== 4'd1) begin
        errors++; $display("FAIL branch case%0d next got %0d want 1", k, state_o);
      end
    end
  endtask

  task automatic test_load_store();
    logic [10:0] exp_v [2][7];
    logic [7:0]  ctl_t [2];
    ctl_t[0] = 8'b0100_0000;  // STORE
    ctl_t[1] = 8'b1010_0000;  // LOAD
    exp_v[0][0] = 11'b0001_0_0_00_0_0_0; exp_v[1][0] = 11'b0001_0_0_00_0_0_0;
    exp_v[0][1] = 11'b0001_1_0_00_0_0_0; exp_v[1][1] = 11'b0001_1_0_00_0_0_0;
    exp_v[0][2] = 11'b0010_0_0_00_0_0_0; exp_v[1][2] = 11'b0010_0_0_00_0_0_0;
    exp_v[0][3] = 11'b0011_0_0_00_0_0_0; exp_v[1][3] = 11'b0011_0_0_00_0_0_0;
    exp_v[0][4] = 11'b0101_0_0_00_0_1_0; exp_v[1][4] = 11'b0101_0_0_00_0_0_0;
    exp_v[0][5] = 11'b0110_0_1_00_0_0_0; exp_v[1][5] = 11'b0110_0_1_00_1_0_0;
    exp_v[0][6] = 11'b0001_0_0_00_0_0_0; exp_v[1][6] = 11'b0001_0_0_00_0_0_0;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      set_ctl(ctl_t[k]);
      launch();
      for (int c = 0; c < 7; c++) begin
        if (c > 0) @(negedge clk);
        checks++;
        if (obs !== exp_v[k][c]) begin
          errors++; $display("FAIL %s cyc%0d got %h want %h", (k == 0) ? "store" : "load", c, obs, exp_v[k][c]);
        end
      end
    end
  endtask

  task automatic test_mul();
    logic [10:0] exp_v [8];
    exp_v[0] = 11'b0001_0_0_00_0_0_0;
    exp_v[1] = 11'b0001_1_0_00_0_0_0;
    exp_v[2] = 11'b0010_0_0_00_0_0_1;
    exp_v[3] = 11'b0100_0_0_00_0_0_0;
    exp_v[4] = 11'b0100_0_0_00_0_0_0;
    exp_v[5] = 11'b0100_0_0_00_0_0_0;
    exp_v[6] = 11'b0110_0_1_00_1_0_0;
    exp_v[7] = 11'b0001_0_0_00_0_0_0;
    do_reset();
    set_ctl(8'b1001_1000);  // MUL with stray BEQ; WB must still use PC+1
    zero = 1'b1;
    mul_done = 1'b1;        // outside MULW: ignored
    launch();
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (obs !== exp_v[c]) begin
        errors++; $display("FAIL mul cyc%0d got %h want %h", c, obs, exp_v[c]);
      end
      if (c == 2) mul_done = 1'b0;
      if (c == 5) mul_done = 1'b1;
      if (c == 6) mul_done = 1'b0;
    end
  endtask

  task automatic test_mul_timeout();
    logic [3:0]  st;
    logic [10:0] e;
    do_reset();
    set_ctl(8'b1001_0000);
    launch();
    for (int c = 0; c < 21; c++) begin
      if (c > 0) @(negedge clk);
      st = (c < 2) ? 4'd1 : (c == 2) ? 4'd2 : (c <= 17) ? 4'd4 : 4'd8;
      e  = {st, (c == 1), 1'b0, 2'b00, 1'b0, 1'b0, (c == 2)};
      checks++;
      if (obs !== e || error_o !== (c >= 18) || halted_o !== 1'b0) begin
        errors++; $display("FAIL timeout cyc%0d got %h err=%b want %h err=%b", c, obs, error_o, e, (c >= 18));
      end
      if (c == 19) start = 1'b1;
      if (c == 20) begin start = 1'b0; mul_done = 1'b1; end
    end
    mul_done = 1'b0;
  endtask

  task automatic test_halt();
    logic [3:0] st;
    do_reset();
    set_ctl(8'b0001_0001);  // HALT has priority over MUL_OP
    launch();
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clk);
      st = (c < 2) ? 4'd1 : (c == 2) ? 4'd2 : 4'd7;
      checks++;
      if (obs !== {st, (c == 1), 6'b0} || halted_o !== (c >= 3) || error_o !== 1'b0) begin
        errors++; $display("FAIL halt cyc%0d got %h halted=%b want %h halted=%b", c, obs, halted_o, {st, (c == 1), 6'b0}, (c >= 3));
      end
      if (c == 4) start = 1'b1;
      if (c == 6) start = 1'b0;
    end
    do_reset();
    checks++;
    if (halted_o !== 1'b0 || state_o !== 4'd0) begin
      errors++; $display("FAIL halt_cleared got halted=%b state=%0d want 0 0", halted_o, state_o);
    end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    set_ctl(8'b0100_0000);
    launch();
    repeat (4) @(negedge clk);
    checks++;
    if (dmem_we_o !== 1'b1 || state_o !== 4'd5) begin
      errors++; $display("FAIL midmem_pre got dmem=%b state=%0d want 1 5", dmem_we_o, state_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dmem_we_o !== 1'b0 || state_o !== 4'd0) begin
      errors++; $display("FAIL midmem_async got dmem=%b state=%0d want 0 0", dmem_we_o, state_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (state_o !== 4'd0) begin
      errors++; $display("FAIL midmem_after got state=%0d want 0", state_o);
    end
  endtask

  task automatic test_back_to_back();
    int wb_cnt;
    int rf_cnt;
    do_reset();
    set_ctl(8'b1000_0000);
`ifdef SEQ_PERF_CNT_EN
    force dut.instr_cnt_q = 16'hFFFE;
    @(posedge clk);
    #1 release dut.instr_cnt_q;
    @(negedge clk);
`endif
    wb_cnt = 0;
    rf_cnt = 0;
    launch();
    for (int c = 0; c < 15; c++) begin
      if (c > 0) @(negedge clk);
      if (pc_we_o === 1'b1) wb_cnt++;
      if (rf_we_o === 1'b1) rf_cnt++;
    end
    @(negedge clk);
    checks++;
    if (wb_cnt !== 3 || rf_cnt !== 3) begin
      errors++; $display("FAIL b2b_writebacks got pc=%0d rf=%0d want 3 3", wb_cnt, rf_cnt);
    end
    checks++;
    if (state_o !== 4'd1) begin
      errors++; $display("FAIL b2b_refetch got state=%0d want 1", state_o);
    end
    checks++;
`ifdef SEQ_PERF_CNT_EN
    if (instr_cnt_o !== 16'hFFFF) begin
      errors++; $display("FAIL instr_cnt_sat got %h want ffff", instr_cnt_o);
    end
    do_reset();
    launch();
    repeat (15) @(negedge clk);
    checks++;
    if (instr_cnt_o !== 16'd3) begin
      errors++; $display("FAIL instr_cnt got %0d want 3", instr_cnt_o);
    end
`else
    if (instr_cnt_o !== 16'h0000) begin
      errors++; $display("FAIL instr_cnt_tied got %h want 0000", instr_cnt_o);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_load_store();
    test_mul();
    test_mul_timeout();
    test_halt();
    test_reset_mid_mem();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
